// File: rtl/encryption_block_fifo.sv
// Buffered stream-cipher stage: queues plaintext words, fetches one keystream word
// per buffered word from the hash generator and emits ciphertext (or plaintext in bypass).
module encryption_block_fifo #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           byte_in,
  input  logic                        byte_in_pulse,
  input  logic                        bypass,
  input  logic                        hash_ready,
  output logic                        request_byte_pulse,
  input  logic [DATA_W-1:0]           hash_byte,
  input  logic                        hash_byte_pulse,
  output logic [DATA_W-1:0]           encrypted_byte_out,
  output logic                        encrypted_byte_pulse,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_full,
  output logic                        overflow_err,
  output logic                        timeout_err,
  input  logic                        clear_errors,
  output logic [CNT_W-1:0]            words_done,
  output logic [1:0]                  state_out
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1) + 1;

  typedef enum logic [1:0] {
    E_IDLE    = 2'd0,
    E_REQUEST = 2'd1,
    E_AWAIT   = 2'd2,
    E_BYPASS  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DATA_W-1:0]   head_c;
  logic [DATA_W-1:0]   enc_data_d;
  logic                enc_pulse_d;
  logic                req_d;
  logic                pop_c;
  logic                push_c;
  logic                overflow_evt_c;
  logic                timeout_evt_c;
  logic                timeout_hit_c;
  logic                fifo_empty_c;

  assign head_c         = mem[rd_ptr_q];
  assign fifo_empty_c   = (fifo_count == '0);
  assign timeout_hit_c  = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign push_c         = byte_in_pulse && (!fifo_full || pop_c);
  assign overflow_evt_c = byte_in_pulse && fifo_full && !pop_c;
  assign state_out      = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= E_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      E_IDLE:    if (!fifo_empty_c) state_d = bypass ? E_BYPASS : E_REQUEST;
      E_REQUEST: if (hash_ready) state_d = E_AWAIT;
      E_AWAIT: begin
        if (hash_byte_pulse)    state_d = E_IDLE;
        else if (timeout_hit_c) state_d = E_REQUEST;
      end
      E_BYPASS:  state_d = E_IDLE;
      default:   state_d = E_IDLE;
    endcase
  end

  // Output / datapath decode
  always_comb begin
    req_d         = 1'b0;
    enc_pulse_d   = 1'b0;
    enc_data_d    = encrypted_byte_out;
    pop_c         = 1'b0;
    timeout_evt_c = 1'b0;
    timer_d       = timer_q;
    case (state_q)
      E_REQUEST: begin
        if (hash_ready) begin
          req_d   = 1'b1;
          timer_d = '0;
        end
      end
      E_AWAIT: begin
        if (hash_byte_pulse) begin
          enc_pulse_d = 1'b1;
          enc_data_d  = head_c ^ hash_byte;
          pop_c       = 1'b1;
        end else if (timeout_hit_c) begin
          timeout_evt_c = 1'b1;
          timer_d       = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      E_BYPASS: begin
        enc_pulse_d = 1'b1;
        enc_data_d  = head_c;
        pop_c       = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      request_byte_pulse   <= 1'b0;
      encrypted_byte_pulse <= 1'b0;
      encrypted_byte_out   <= '0;
      words_done           <= '0;
      timer_q              <= '0;
    end else begin
      request_byte_pulse   <= req_d;
      encrypted_byte_pulse <= enc_pulse_d;
      encrypted_byte_out   <= enc_data_d;
      timer_q              <= timer_d;
      if (pop_c) words_done <= words_done + CNT_W'(1);
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= byte_in;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10: begin
          fifo_count <= fifo_count + CNT_FW'(1);
          fifo_full  <= (fifo_count == CNT_FW'(FIFO_DEPTH - 1));
        end
        2'b01: begin
          fifo_count <= fifo_count - CNT_FW'(1);
          fifo_full  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (overflow_evt_c)    overflow_err <= 1'b1;
      else if (clear_errors) overflow_err <= 1'b0;
      if (timeout_evt_c)     timeout_err  <= 1'b1;
      else if (clear_errors) timeout_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encryption_block_fifo.sv
// Self-checking bench for encryption_block_fifo: directed scenarios plus randomized
// traffic scored against a queue-based reference model.
module tb_encryption_block_fifo;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 4;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] byte_in;
  logic              byte_in_pulse;
  logic              bypass;
  logic              hash_ready;
  logic              request_byte_pulse;
  logic [DATA_W-1:0] hash_byte;
  logic              hash_byte_pulse;
  logic [DATA_W-1:0] encrypted_byte_out;
  logic              encrypted_byte_pulse;
  logic [2:0]        fifo_count;
  logic              fifo_full;
  logic              overflow_err;
  logic              timeout_err;
  logic              clear_errors;
  logic [CNT_W-1:0]  words_done;
  logic [1:0]        state_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] pt_q[$];
  logic [DATA_W-1:0] ks_q[$];
  logic [CNT_W-1:0]  words_exp;

  encryption_block_fifo #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_in_pulse(byte_in_pulse),
    .bypass(bypass), .hash_ready(hash_ready), .request_byte_pulse(request_byte_pulse),
    .hash_byte(hash_byte), .hash_byte_pulse(hash_byte_pulse),
    .encrypted_byte_out(encrypted_byte_out), .encrypted_byte_pulse(encrypted_byte_pulse),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow_err(overflow_err),
    .timeout_err(timeout_err), .clear_errors(clear_errors), .words_done(words_done),
    .state_out(state_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; byte_in_pulse = 1'b0; hash_byte_pulse = 1'b0; clear_errors = 1'b0;
    bypass = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    byte_in = v; byte_in_pulse = 1'b1;
    tick();
    byte_in_pulse = 1'b0;
  endtask

  task automatic wait_req(input int budget, output int n);
    n = 0;
    while (!request_byte_pulse && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Wait for a request, answer in the same cycle, check the ciphertext a cycle later.
  task automatic serve(input string tag, input logic [DATA_W-1:0] pt);
    int n;
    logic [DATA_W-1:0] k;
    wait_req(20, n);
    check({tag, "_req"}, 32'(request_byte_pulse), 32'd1);
    k = DATA_W'($urandom);
    hash_byte = k; hash_byte_pulse = 1'b1;
    tick();
    hash_byte_pulse = 1'b0;
    check({tag, "_pulse"}, 32'(encrypted_byte_pulse), 32'd1);
    check({tag, "_data"}, 32'(encrypted_byte_out), 32'(pt ^ k));
  endtask

  // Random traffic against the queue model; bypass fixed for the whole run.
  task automatic run_random(input bit byp, input int n_cycles);
    int cyc = 0;
    int dly = 0;
    logic [DATA_W-1:0] v, k, exp;
    bypass = byp;
    while ((cyc < n_cycles || pt_q.size() != 0) && cyc < n_cycles + 400) begin
      tick();
      cyc++;
      if (encrypted_byte_pulse) begin
        check("rnd_pending", 32'(pt_q.size() != 0), 32'd1);
        exp = (pt_q.size() != 0) ? pt_q.pop_front() : '0;
        if (!byp) begin
          check("rnd_ks_avail", 32'(ks_q.size() != 0), 32'd1);
          if (ks_q.size() != 0) exp = exp ^ ks_q.pop_front();
        end
        check(byp ? "rnd_byp_data" : "rnd_enc_data", 32'(encrypted_byte_out), 32'(exp));
        words_exp = words_exp + CNT_W'(1);
        check("rnd_words_done", 32'(words_done), 32'(words_exp));
      end
      if (byp) check("rnd_byp_noreq", 32'(request_byte_pulse), 32'd0);
      hash_byte_pulse = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          k = DATA_W'($urandom);
          hash_byte = k; hash_byte_pulse = 1'b1;
          ks_q.push_back(k);
        end
      end else if (!byp && request_byte_pulse) begin
        dly = $urandom_range(1, 5);
      end
      byte_in_pulse = 1'b0;
      if (cyc < n_cycles && ($urandom_range(0, 2) == 0) && pt_q.size() < DEPTH) begin
        v = DATA_W'($urandom);
        byte_in = v; byte_in_pulse = 1'b1;
        pt_q.push_back(v);
      end
      hash_ready = ($urandom_range(0, 3) != 0);
    end
    hash_byte_pulse = 1'b0; byte_in_pulse = 1'b0;
    check("rnd_drained", 32'(pt_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int reqs;
    logic [DATA_W-1:0] k;
    rst = 1'b1; byte_in = '0; byte_in_pulse = 1'b0; bypass = 1'b0; hash_ready = 1'b0;
    hash_byte = '0; hash_byte_pulse = 1'b0; clear_errors = 1'b0;

    // Reset state
    do_reset();
    check("rst_req",      32'(request_byte_pulse),   32'd0);
    check("rst_pulse",    32'(encrypted_byte_pulse), 32'd0);
    check("rst_out",      32'(encrypted_byte_out),   32'd0);
    check("rst_count",    32'(fifo_count),           32'd0);
    check("rst_full",     32'(fifo_full),            32'd0);
    check("rst_ovf",      32'(overflow_err),         32'd0);
    check("rst_tmo",      32'(timeout_err),          32'd0);
    check("rst_words",    32'(words_done),           32'd0);
    check("rst_state",    32'(state_out),            32'd0);

    // T1: single word through the cipher
    hash_ready = 1'b1;
    push(8'hA5);
    check("t1_count", 32'(fifo_count), 32'd1);
    wait_req(20, n);
    check("t1_req_lat", 32'(n), 32'd2);
    hash_byte = 8'h3C; hash_byte_pulse = 1'b1;
    tick();
    hash_byte_pulse = 1'b0;
    check("t1_pulse", 32'(encrypted_byte_pulse), 32'd1);
    check("t1_data",  32'(encrypted_byte_out),   32'h99);
    check("t1_words", 32'(words_done),           32'd1);
    check("t1_count_after", 32'(fifo_count),     32'd0);
    tick();
    check("t1_pulse_once", 32'(encrypted_byte_pulse), 32'd0);
    check("t1_hold", 32'(encrypted_byte_out), 32'h99);

    // T2: overflow with stalled hash; clear in the same cycle as the error loses
    do_reset();
    hash_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      byte_in = DATA_W'(i); byte_in_pulse = 1'b1; clear_errors = (i == 5);
      tick();
    end
    byte_in_pulse = 1'b0; clear_errors = 1'b0;
    check("t2_count", 32'(fifo_count),   32'd4);
    check("t2_full",  32'(fifo_full),    32'd1);
    check("t2_ovf",   32'(overflow_err), 32'd1);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check("t2_ovf_clr", 32'(overflow_err), 32'd0);
    hash_ready = 1'b1;
    // Push into a full FIFO in the pop cycle: both happen, no overflow
    wait_req(20, n);
    check("t2_req0", 32'(request_byte_pulse), 32'd1);
    k = DATA_W'($urandom);
    hash_byte = k; hash_byte_pulse = 1'b1; byte_in = 8'h06; byte_in_pulse = 1'b1;
    tick();
    hash_byte_pulse = 1'b0; byte_in_pulse = 1'b0;
    check("t2_w1_data", 32'(encrypted_byte_out), 32'(8'h01 ^ k));
    check("t2_pp_count", 32'(fifo_count), 32'd4);
    check("t2_pp_ovf", 32'(overflow_err), 32'd0);
    serve("t2_w2", 8'h02);
    serve("t2_w3", 8'h03);
    serve("t2_w4", 8'h04);
    serve("t2_w6", 8'h06);
    check("t2_empty", 32'(fifo_count), 32'd0);
    check("t2_words", 32'(words_done), 32'd5);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (request_byte_pulse) reqs++;
    end
    check("t2_lost_word", 32'(reqs), 32'd0);

    // T3: hash not ready holds off the request
    do_reset();
    hash_ready = 1'b0;
    push(8'h11);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (request_byte_pulse) reqs++;
    end
    check("t3_no_req", 32'(reqs), 32'd0);
    check("t3_state", 32'(state_out), 32'd1);
    hash_ready = 1'b1;
    tick();
    check("t3_req_after_ready", 32'(request_byte_pulse), 32'd1);
    serve("t3_w", 8'h11);

    // T4: keystream timeout and retry
    do_reset();
    hash_ready = 1'b1;
    push(8'h0F);
    wait_req(20, n);
    n = 0;
    while (state_out == 2'd2 && n < 20) begin
      check("t4_no_early_tmo", 32'(timeout_err), 32'd0);
      tick();
      n++;
    end
    check("t4_await_cycles", 32'(n), 32'(TIMEOUT));
    check("t4_tmo", 32'(timeout_err), 32'd1);
    check("t4_state_req", 32'(state_out), 32'd1);
    check("t4_count", 32'(fifo_count), 32'd1);
    tick();
    check("t4_rereq", 32'(request_byte_pulse), 32'd1);
    hash_byte = 8'hFF; hash_byte_pulse = 1'b1;
    tick();
    hash_byte_pulse = 1'b0;
    check("t4_data", 32'(encrypted_byte_out), 32'hF0);
    check("t4_tmo_sticky", 32'(timeout_err), 32'd1);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check("t4_tmo_clr", 32'(timeout_err), 32'd0);

    // T5: bypass passes plaintext without a request
    do_reset();
    bypass = 1'b1;
    push(8'h5A);
    reqs = 0;
    tick();
    if (request_byte_pulse) reqs++;
    check("t5_state_byp", 32'(state_out), 32'd3);
    tick();
    if (request_byte_pulse) reqs++;
    check("t5_pulse", 32'(encrypted_byte_pulse), 32'd1);
    check("t5_data", 32'(encrypted_byte_out), 32'h5A);
    check("t5_no_req", 32'(reqs), 32'd0);
    check("t5_words", 32'(words_done), 32'd1);
    bypass = 1'b0;

    // T6: reset while awaiting discards the request; stray pulse ignored
    do_reset();
    hash_ready = 1'b1;
    push(8'h33);
    wait_req(20, n);
    check("t6_in_await", 32'(state_out), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hash_byte = 8'hAA; hash_byte_pulse = 1'b1;
    tick();
    hash_byte_pulse = 1'b0;
    check("t6_no_out", 32'(encrypted_byte_pulse), 32'd0);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_state", 32'(state_out), 32'd0);
    check("t6_tmo", 32'(timeout_err), 32'd0);
    check("t6_words", 32'(words_done), 32'd0);

    // Random traffic: cipher mode then bypass mode; words_done wraps at 2^CNT_W
    do_reset();
    words_exp = '0;
    pt_q.delete(); ks_q.delete();
    run_random(1'b0, 1500);
    run_random(1'b1, 400);
    check("rnd_ovf", 32'(overflow_err), 32'd0);
    check("rnd_tmo", 32'(timeout_err), 32'd0);
    check("rnd_final_count", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
